scan_sequencer_2b: RTL and testbench
====================================

Name: scan_sequencer_2b

Overview:
- Sequencer that sits directly upstream of the 2x4 one-hot decoder.
- Generates the decoder's 2-bit select I[1:0] and enable En so that the decoder's four outputs are strobed one at a time in round-robin order.
- Intended use is multiplexed display digits or row scanning.
- Supports a per-slot dwell time, a blanking gap between slots, a slot skip mask, graceful stop and a frame-complete pulse.

Parameters:
- CNT_W, 16, width of the dwell and gap counters and of the dwell/gap inputs.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- run  input  1  level; 1 = scan, 0 = stop after the current slot completes.
- mask  input  4  slot enable, bit n = slot n participates; sampled at every slot-load point.
- dwell  input  CNT_W  En-high length minus one; sampled at slot load.
- gap  input  CNT_W  blanking length in cycles, 0 = no blanking; sampled at slot load.
- I  output  2  decoder select, registered.
- En  output  1  decoder enable, registered.
- slot_done  output  1  one-cycle pulse in the first cycle after a slot's last En=1 cycle.
- frame_done  output  1  one-cycle pulse, coincident with slot_done, when the finished slot is the highest-numbered set bit of the mask sampled at that slot's load.

Behaviour:
- Reset (rst_n=0 at a clock edge) forces the following, regardless of state; reset mid-slot aborts the slot:
  - state=IDLE, I=2'b00, En=0, slot_done=0, frame_done=0, counters=0.
- States: IDLE, ACTIVE, BLANK.
- IDLE:
  - En=0 and I holds its last value.
  - On an edge with run=1 and mask!=0: load slot = lowest set bit of mask, load dwell_cnt=dwell and gap_len=gap, go to ACTIVE.
  - En=1 and the new I are both visible after that same edge, giving one cycle of latency from run being sampled.
  - run=1 with mask=0: stay in IDLE.
- ACTIVE:
  - En=1 for exactly dwell+1 cycles; dwell=0 gives one cycle.
  - dwell_cnt decrements each cycle; at dwell_cnt==0 the slot ends.
  - Slot end with gap_len!=0: go to BLANK, En=0, I holds.
  - Slot end with gap_len==0: go directly to the slot-advance decision in the same edge.
- BLANK:
  - En=0 for exactly gap_len cycles, then the slot-advance decision is taken.
- Slot-advance decision, evaluated once per slot at the edge that ends ACTIVE (gap=0) or BLANK:
  - run=0 or current mask=0: go to IDLE, En=0.
  - Otherwise: next slot = next set bit of mask strictly above the current slot, wrapping 3->0. With a single set bit, the same slot repeats.
  - Load dwell and gap, go to ACTIVE.
- Glitch rule: I changes only on edges where En is 0 in the preceding cycle. The one exception is gap=0 with back-to-back slots, where I and En update on the same edge.
- slot_done/frame_done timing: asserted for one cycle, in the cycle after the slot's final En=1 cycle. This is the first BLANK cycle, or the first cycle of the next slot or of IDLE when gap=0.
- Changes on mask/dwell/gap mid-slot have no effect until the next slot-load point.
- run dropping mid-slot: the current dwell and gap complete in full and slot_done still pulses; then IDLE.
- Counters are unsigned CNT_W bits. dwell=2^CNT_W-1 gives 2^CNT_W cycles with no overflow.

Test Plan:
1. Reset, then run=1, mask=4'b1111, dwell=2, gap=1 -> En high 3 cycles / low 1 cycle, I sequence 0,1,2,3,0.
   - 16-cycle frame; slot_done every 4 cycles; frame_done once per 16 cycles, after slot 3.
2. mask=4'b1010, dwell=0, gap=0 -> En stays 1 continuously, I alternates 1,3,1,3 every cycle.
   - slot_done every cycle; frame_done on every second slot (after I=3).
3. mask=4'b0100, dwell=1, gap=2 -> I constant 2, En pattern 1,1,0,0 repeating; slot_done and frame_done every 4 cycles.
4. run dropped during cycle 2 of slot 1 (mask=4'b1111, dwell=3, gap=1):
   - Slot 1 completes 4 En cycles plus 1 blank, slot_done pulses, then IDLE.
   - En stays 0 and I stays 1 thereafter.
5. rst_n=0 during ACTIVE on slot 2 -> next edge gives En=0, I=0, pulses 0.
   - Restart with run=1 begins at slot 0, or at the lowest set mask bit.
6. Mask changed from 4'b1111 to 4'b0001 while in slot 1 -> slot 1 finishes normally, next slot 0; mask changed to 4'b0000 instead -> IDLE after slot 1.

Source files
------------

// File: rtl/scan_sequencer_2b.sv
// Round-robin scan sequencer that drives the select and enable of a 2x4 one-hot decoder.
// Each slot has a dwell time and an optional blanking gap. A mask selects which slots take part.
module scan_sequencer_2b #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [3:0]       mask,
  input  logic [CNT_W-1:0] dwell,
  input  logic [CNT_W-1:0] gap,
  output logic [1:0]       I,
  output logic             En,
  output logic             slot_done,
  output logic             frame_done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

  state_t           state, state_nx;
  logic [1:0]       slot_nx, hi, hi_nx;
  logic             en_nx, sd_nx, fd_nx, load, adv;
  logic [CNT_W-1:0] dwell_cnt, dwell_cnt_nx;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_nx;
  logic [CNT_W-1:0] gap_len, gap_len_nx;

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (m[k]) r = 2'(k);
    return r;
  endfunction

  function automatic logic [1:0] highest_bit(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k <= 3; k++)
      if (m[k]) r = 2'(k);
    return r;
  endfunction

  // The search starts just above cur and wraps. cur itself is the last candidate, so a single-bit mask repeats that slot.
  function automatic logic [1:0] next_bit(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] idx;
    r = cur;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  always_comb begin
    state_nx     = state;
    slot_nx      = I;
    hi_nx        = hi;
    en_nx        = 1'b0;
    sd_nx        = 1'b0;
    fd_nx        = 1'b0;
    load         = 1'b0;
    adv          = 1'b0;
    dwell_cnt_nx = dwell_cnt;
    gap_cnt_nx   = gap_cnt;
    gap_len_nx   = gap_len;

    case (state)
      IDLE: begin
        if (run && (mask != 4'b0000)) begin
          load    = 1'b1;
          slot_nx = lowest_bit(mask);
        end
      end
      ACTIVE: begin
        en_nx = 1'b1;
        if (dwell_cnt == '0) begin
          en_nx = 1'b0;
          sd_nx = 1'b1;
          fd_nx = (I == hi);
          if (gap_len != '0) begin
            state_nx   = BLANK;
            gap_cnt_nx = gap_len - 1'b1;
          end else begin
            adv = 1'b1;
          end
        end else begin
          dwell_cnt_nx = dwell_cnt - 1'b1;
        end
      end
      BLANK: begin
        if (gap_cnt == '0) adv = 1'b1;
        else               gap_cnt_nx = gap_cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    // Slot-advance decision: run and mask are only consulted here and in IDLE.
    if (adv) begin
      if (!run || (mask == 4'b0000)) begin
        state_nx = IDLE;
      end else begin
        load    = 1'b1;
        slot_nx = next_bit(mask, I);
      end
    end

    if (load) begin
      state_nx     = ACTIVE;
      en_nx        = 1'b1;
      dwell_cnt_nx = dwell;
      gap_len_nx   = gap;
      hi_nx        = highest_bit(mask);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      I          <= 2'b00;
      En         <= 1'b0;
      slot_done  <= 1'b0;
      frame_done <= 1'b0;
      hi         <= 2'b00;
      dwell_cnt  <= '0;
      gap_cnt    <= '0;
      gap_len    <= '0;
    end else begin
      state      <= state_nx;
      I          <= slot_nx;
      En         <= en_nx;
      slot_done  <= sd_nx;
      frame_done <= fd_nx;
      hi         <= hi_nx;
      dwell_cnt  <= dwell_cnt_nx;
      gap_cnt    <= gap_cnt_nx;
      gap_len    <= gap_len_nx;
    end
  end

endmodule

// File: tb/tb_scan_sequencer_2b.sv
// Bench for scan_sequencer_2b: a schedule-queue reference model predicts I/En/slot_done/frame_done for every cycle.
// Directed scenarios and random traffic are compared against it.
module tb_scan_sequencer_2b;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n, run;
  logic [3:0]       mask;
  logic [CNT_W-1:0] dwell, gap;
  logic [1:0]       I;
  logic             En, slot_done, frame_done;

  int total = 0;
  int bad   = 0;

  scan_sequencer_2b #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mask(mask), .dwell(dwell), .gap(gap),
    .I(I), .En(En), .slot_done(slot_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] i;
    logic       en;
    logic       sd;
    logic       fd;
  } exp_t;

  function automatic exp_t mk(input int i, input bit en, input bit sd, input bit fd);
    exp_t r;
    r.i  = 2'(i);
    r.en = en;
    r.sd = sd;
    r.fd = fd;
    return r;
  endfunction

  // The model sees each slot as a list of future output cycles. When the list runs out, it makes the next decision.
  exp_t q[$];
  exp_t e;
  bit   pend_sd, pend_fd, scanning;
  int   cur, last_i, s, hi;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      e        = '0;
      pend_sd  = 0;
      pend_fd  = 0;
      scanning = 0;
      last_i   = 0;
      cur      = 0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
    end else if (run && mask != 4'b0000) begin
      s = -1;
      if (scanning)
        for (int k = cur + 1; k <= 3; k++) if (s < 0 && mask[k]) s = k;
      if (s < 0)
        for (int k = 0; k <= 3; k++) if (s < 0 && mask[k]) s = k;
      hi = 0;
      for (int k = 0; k <= 3; k++) if (mask[k]) hi = k;
      for (int k = 0; k <= int'(dwell); k++)
        q.push_back(mk(s, 1, (k == 0) ? pend_sd : 1'b0, (k == 0) ? pend_fd : 1'b0));
      for (int k = 0; k < int'(gap); k++)
        q.push_back(mk(s, 0, k == 0, (k == 0) && (s == hi)));
      pend_sd  = (gap == 0);
      pend_fd  = (gap == 0) && (s == hi);
      cur      = s;
      last_i   = s;
      scanning = 1;
      e = q.pop_front();
    end else begin
      e        = mk(last_i, 0, pend_sd, pend_fd);
      pend_sd  = 0;
      pend_fd  = 0;
      scanning = 0;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; mask = 4'b0000; dwell = '0; gap = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({I, En, slot_done, frame_done} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_state: got=%b want=00000", {I, En, slot_done, frame_done});
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({I, En, slot_done, frame_done} !== e) begin
        bad++;
        $display("FAIL reset_idle: got=%b want=%b", {I, En, slot_done, frame_done}, e);
      end
    end
  endtask

  task automatic test_round_robin();
    int nsd, nfd;
    nsd = 0; nfd = 0;
    run = 1'b1; mask = 4'b1111; dwell = 2; gap = 1;
    repeat (32) begin
      @(negedge clk);
      nsd += int'(slot_done);
      nfd += int'(frame_done);
      total++;
      if ({I, En, slot_done, frame_done} !== e) begin
        bad++;
        $display("FAIL round_robin: got=%b want=%b", {I, En, slot_done, frame_done}, e);
      end
    end
    total++;
    if (nsd != 8 || nfd != 2) begin
      bad++;
      $display("FAIL round_robin_pulses: got sd=%0d fd=%0d want sd=8 fd=2", nsd, nfd);
    end
    run = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1; mask = 4'b1010; dwell = 0; gap = 0;
    @(negedge clk);
    total++;
    if ({I, En} !== 3'b011) begin
      bad++;
      $display("FAIL b2b_first: got I=%0d En=%b want I=1 En=1", I, En);
    end
    repeat (20) begin
      @(negedge clk);
      total++;
      if ({I, En, slot_done, frame_done} !== e) begin
        bad++;
        $display("FAIL back_to_back: got=%b want=%b", {I, En, slot_done, frame_done}, e);
      end
    end
    mask = 4'b0100; dwell = 1; gap = 2;
    repeat (24) begin
      @(negedge clk);
      total++;
      if ({I, En, slot_done, frame_done} !== e) begin
        bad++;
        $display("FAIL single_slot: got=%b want=%b", {I, En, slot_done, frame_done}, e);
      end
    end
  endtask

  task automatic test_stop();
    int n;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1; mask = 4'b1111; dwell = 3; gap = 1;
    n = 0;
    while (!(e.i == 2'd1 && e.en) && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL stop_wait: got timeout want slot 1");
    end
    @(negedge clk);
    run = 1'b0;
    repeat (14) begin
      @(negedge clk);
      total++;
      if ({I, En, slot_done, frame_done} !== e) begin
        bad++;
        $display("FAIL stop: got=%b want=%b", {I, En, slot_done, frame_done}, e);
      end
    end
    total++;
    if (I !== 2'd1 || En !== 1'b0) begin
      bad++;
      $display("FAIL stop_final: got I=%0d En=%b want I=1 En=0", I, En);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    run = 1'b1; mask = 4'b1111; dwell = 5; gap = 1;
    n = 0;
    while (!(e.i == 2'd2 && e.en) && n < 80) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 80) begin
      bad++;
      $display("FAIL rstmid_wait: got timeout want slot 2");
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({I, En, slot_done, frame_done} !== 5'b00000) begin
      bad++;
      $display("FAIL rstmid_state: got=%b want=00000", {I, En, slot_done, frame_done});
    end
    rst_n = 1'b1; mask = 4'b1100; dwell = 1; gap = 0;
    @(negedge clk);
    total++;
    if ({I, En} !== 3'b101) begin
      bad++;
      $display("FAIL rstmid_restart: got I=%0d En=%b want I=2 En=1", I, En);
    end
    repeat (10) begin
      @(negedge clk);
      total++;
      if ({I, En, slot_done, frame_done} !== e) begin
        bad++;
        $display("FAIL rstmid_run: got=%b want=%b", {I, En, slot_done, frame_done}, e);
      end
    end
  endtask

  task automatic test_mask_change(input logic [3:0] new_mask);
    int n;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1; mask = 4'b1111; dwell = 3; gap = 1;
    n = 0;
    while (!(e.i == 2'd1 && e.en) && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL maskchg_wait: got timeout want slot 1");
    end
    mask = new_mask;
    repeat (16) begin
      @(negedge clk);
      total++;
      if ({I, En, slot_done, frame_done} !== e) begin
        bad++;
        $display("FAIL mask_change_%b: got=%b want=%b", new_mask, {I, En, slot_done, frame_done}, e);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      total++;
      if ({I, En, slot_done, frame_done} !== e) begin
        bad++;
        $display("FAIL random cyc %0d: got=%b want=%b", c, {I, En, slot_done, frame_done}, e);
      end
      rst_n = ($urandom_range(0, 63) != 0);
      run   = ($urandom_range(0, 7) != 0);
      mask  = 4'($urandom_range(0, 15));
      dwell = CNT_W'($urandom_range(0, 3));
      gap   = CNT_W'($urandom_range(0, 2));
    end
  endtask

  task automatic test_long_dwell();
    int nen;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1; mask = 4'b0001; dwell = '1; gap = 0;
    nen = 0;
    @(negedge clk);
    run = 1'b0;
    while (En === 1'b1 && nen < 70000) begin
      nen++;
      total++;
      if ({I, En, slot_done, frame_done} !== e) begin
        bad++;
        $display("FAIL long_dwell: got=%b want=%b", {I, En, slot_done, frame_done}, e);
      end
      @(negedge clk);
    end
    total++;
    if (nen != 65536 || slot_done !== 1'b1 || frame_done !== 1'b1) begin
      bad++;
      $display("FAIL long_dwell_len: got len=%0d sd=%b fd=%b want len=65536 sd=1 fd=1", nen, slot_done, frame_done);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_stop();
    test_reset_mid();
    test_mask_change(4'b0001);
    test_mask_change(4'b0000);
    test_random();
    test_long_dwell();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
